// File: rtl/harp_uart_scheduler.sv
// Sole owner of the sync-output UART: interleaves time-critical Harp sync frames
// with an auxiliary byte stream, granting aux bytes only when they cannot delay a frame.
module harp_uart_scheduler #(
    parameter int CLK_HZ       = 1000000,
    parameter int BAUD         = 100000,
    parameter int LEAD_CYCLES  = 672,
    parameter int GUARD_CYCLES = 110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  aux_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    output logic [7:0]  uart_data,
    output logic        uart_start,
    input  logic        uart_finish,
    output logic        uart_blank,
    output logic [31:0] seconds,
    output logic        LED
);

    localparam int BYTE_CYCLES = 10 * CLK_HZ / BAUD;
    // A guard shorter than one byte time would let an aux byte overlap the frame start.
    localparam int EFF_GUARD   = (GUARD_CYCLES > BYTE_CYCLES) ? GUARD_CYCLES : BYTE_CYCLES;
    localparam int TRIG_CYC    = CLK_HZ - LEAD_CYCLES;
    localparam int WIN_END     = TRIG_CYC - EFF_GUARD;
    localparam int LED_END     = CLK_HZ / 10;
    localparam int CW          = $clog2(CLK_HZ);

    typedef enum logic [2:0] {IDLE, SYNC_START, SYNC_WAIT, AUX_START, AUX_WAIT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cyc_reg, cyc_next;
    logic [31:0]   stamp_reg;
    logic [2:0]    byte_idx_reg, byte_idx_next;
    logic          frame_pend_reg, frame_pend_next;
    logic [7:0]    data_reg, data_next;
    logic          led_reg;
    logic          start;
    logic          live;
    logic          wrap;
    logic          trigger;
    logic [7:0]    frame_bytes [6];

    // The reset term keeps every run-qualified output at its reset value while reset is held.
    assign live    = run & reset;
    assign wrap    = (cyc_reg == CW'(CLK_HZ - 1));
    assign trigger = live & (cyc_reg == CW'(TRIG_CYC));

    always_comb begin
        cyc_next = '0;
        if (live && !wrap)
            cyc_next = cyc_reg + CW'(1);
    end

    assign frame_bytes[0] = 8'hAA;
    assign frame_bytes[1] = 8'hAF;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stamp
            assign frame_bytes[gi + 2] = stamp_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_reg   <= '0;
            seconds   <= '0;
            stamp_reg <= '0;
            led_reg   <= 1'b0;
        end else begin
            cyc_reg <= cyc_next;
            led_reg <= live & (cyc_next < CW'(LED_END));
            if (!live)
                seconds <= '0;
            else if (wrap)
                seconds <= seconds + 32'd1;
            if (trigger)
                stamp_reg <= seconds + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            byte_idx_reg   <= '0;
            frame_pend_reg <= 1'b0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            frame_pend_reg <= frame_pend_next;
            data_reg       <= data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        frame_pend_next = frame_pend_reg;
        data_next       = data_reg;
        start           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_pend_reg) begin
                    data_next  = frame_bytes[0];
                    state_next = SYNC_START;
                end else if (aux_valid && aux_ready) begin
                    data_next  = aux_data;
                    state_next = AUX_START;
                end
            end
            SYNC_START: begin
                start      = live;
                state_next = live ? SYNC_WAIT : IDLE;
            end
            SYNC_WAIT: begin
                if (uart_finish) begin
                    if (!live) begin
                        state_next = IDLE;
                    end else if (byte_idx_reg == 3'd5) begin
                        byte_idx_next   = '0;
                        frame_pend_next = 1'b0;
                        state_next      = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 3'd1;
                        data_next     = frame_bytes[byte_idx_reg + 3'd1];
                        state_next    = SYNC_START;
                    end
                end
            end
            AUX_START: begin
                start      = live;
                state_next = live ? AUX_WAIT : IDLE;
            end
            AUX_WAIT: begin
                // A frame that became pending behind this byte goes straight out.
                if (uart_finish) begin
                    if (frame_pend_reg && live) begin
                        data_next  = frame_bytes[0];
                        state_next = SYNC_START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (trigger)
            frame_pend_next = 1'b1;
        if (!live) begin
            frame_pend_next = 1'b0;
            byte_idx_next   = '0;
        end
    end

    assign aux_ready  = (state_reg == IDLE) & live & (cyc_reg < CW'(WIN_END)) & !frame_pend_reg;
    assign uart_start = start;
    assign uart_data  = data_reg;
    assign uart_blank = !live & (state_reg == IDLE);
    assign LED        = led_reg;

endmodule

// File: tb/tb_harp_uart_scheduler.sv
// Directed bench for harp_uart_scheduler: a uart_tx model plus a scoreboard of
// expected bytes and their start cycles, checked whenever uart_start fires.
module tb_harp_uart_scheduler;

    localparam int CLK_HZ = 10000;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  aux_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [7:0]  uart_data;
    logic        uart_start;
    logic        uart_finish;
    logic        uart_blank;
    logic [31:0] seconds;
    logic        led;

    harp_uart_scheduler #(
        .CLK_HZ(CLK_HZ), .BAUD(1000), .LEAD_CYCLES(672), .GUARD_CYCLES(110)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .aux_data(aux_data), .aux_valid(aux_valid), .aux_ready(aux_ready),
        .uart_data(uart_data), .uart_start(uart_start), .uart_finish(uart_finish),
        .uart_blank(uart_blank), .seconds(seconds), .LED(led)
    );

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tcyc = 0;
    int   fin_delay = 100;
    int   left = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] s, input int c0, input int n);
        logic [7:0] fb [6];
        fb[0] = 8'hAA; fb[1] = 8'hAF;
        fb[2] = s[7:0]; fb[3] = s[15:8]; fb[4] = s[23:16]; fb[5] = s[31:24];
        for (int i = 0; i < n; i++) sb.push_back('{b: fb[i], c: c0 + 101 * i});
    endtask

    task automatic wait_for(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tcyc != c && n < 25000);
        if (tcyc != c) check("wait_cyc_timeout", 32'(tcyc), 32'(c));
    endtask

    task automatic wait_queue(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference timebase: counts posedges with run high.
    initial forever begin
        @(posedge clk);
        if (!reset || !run) tcyc = 0;
        else tcyc = (tcyc == CLK_HZ - 1) ? 0 : tcyc + 1;
    end

    // uart_tx model and scoreboard consumer.
    initial begin
        uart_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_start) begin
                if (sb.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("uart_data", 32'(uart_data), 32'(e.b));
                    if (e.c >= 0) check("start_cyc", 32'(tcyc), 32'(e.c));
                    $display("tx byte %02h at cyc %0d (expected %02h at %0d)", uart_data, tcyc, e.b, e.c);
                end
            end
            uart_finish = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) uart_finish = 1'b1;
            end
            if (uart_start) left = fin_delay;
        end
    end

    initial begin
        logic [7:0] dat;
        int         last_g;
        int         ng;
        bit         late;
        bit         frame_pushed;

        reset = 1'b0; run = 1'b0; aux_valid = 1'b0; aux_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uart_start", 32'(uart_start), 32'd0);
        check("rst_uart_data", 32'(uart_data), 32'd0);
        check("rst_aux_ready", 32'(aux_ready), 32'd0);
        check("rst_uart_blank", 32'(uart_blank), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_seconds", seconds, 32'd0);

        // Frame content over two seconds
        push_frame(32'd1, 9330, 6);
        push_frame(32'd2, 9330, 6);
        step();
        reset = 1'b1; run = 1'b1;
        wait_for(500);
        check("led_on", 32'(led), 32'd1);
        check("blank_running", 32'(uart_blank), 32'd0);
        wait_for(1500);
        check("led_off", 32'(led), 32'd0);
        wait_for(5);
        check("seconds_1", seconds, 32'd1);
        wait_queue(12000);
        repeat (110) @(negedge clk);

        // Aux stream held valid up to the guard edge
        wait_for(0);
        step();
        dat = 8'h10; aux_data = dat; aux_valid = 1'b1;
        ng = 0; last_g = 0; late = 1'b0; frame_pushed = 1'b0;
        for (int n = 0; n < 12000; n++) begin
            @(negedge clk);
            if (tcyc == 9400) break;
            if (aux_ready && tcyc >= 9218) late = 1'b1;
            if (tcyc == 9300 && !frame_pushed) begin
                push_frame(32'd3, 9330, 6);
                frame_pushed = 1'b1;
            end
            if (aux_valid && aux_ready) begin
                sb.push_back('{b: dat, c: tcyc + 1});
                if (ng > 0) check("aux_spacing", 32'(tcyc - last_g), 32'd102);
                last_g = tcyc;
                ng++;
                step();
                dat = dat + 8'd1;
                aux_data = dat;
            end
        end
        step();
        aux_valid = 1'b0;
        check("aux_late_ready", 32'(late), 32'd0);
        check("aux_last_grant", 32'(last_g >= 9116 && last_g <= 9217), 32'd1);
        wait_queue(2000);
        repeat (110) @(negedge clk);

        // Collision: long aux byte overlapping the trigger
        wait_for(9198);
        step();
        aux_data = 8'h5A; aux_valid = 1'b1; fin_delay = 150;
        @(negedge clk);
        check("coll_aux_ready", 32'(aux_ready), 32'd1);
        sb.push_back('{b: 8'h5A, c: 9200});
        push_frame(32'd4, 9351, 6);
        step();
        aux_valid = 1'b0;
        step();
        fin_delay = 100;
        wait_for(9340);
        check("coll_ready_low", 32'(aux_ready), 32'd0);
        wait_queue(2000);
        repeat (110) @(negedge clk);

        // Abort: run dropped during frame byte 3
        push_frame(32'd5, 9330, 4);
        wait_for(9680);
        step();
        run = 1'b0;
        @(negedge clk);
        check("abort_blank_busy", 32'(uart_blank), 32'd0);
        repeat (150) @(negedge clk);
        check("abort_blank_idle", 32'(uart_blank), 32'd1);
        check("abort_seconds", seconds, 32'd0);
        check("abort_led", 32'(led), 32'd0);
        check("abort_queue", 32'(sb.size()), 32'd0);

        // Restart from zero, then seconds wrap in the timestamp
        push_frame(32'd0, 9330, 6);
        step();
        run = 1'b1;
        wait_for(100);
        check("restart_seconds", seconds, 32'd0);
        wait_for(9000);
        force dut.seconds = 32'hFFFF_FFFF;
        wait_for(9340);
        release dut.seconds;
        wait_queue(2000);
        repeat (110) @(negedge clk);

        // Asynchronous reset in the middle of an aux byte
        wait_for(50);
        step();
        aux_data = 8'hC3; aux_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (aux_valid && aux_ready) begin
                sb.push_back('{b: 8'hC3, c: tcyc + 1});
                break;
            end
        end
        step();
        aux_valid = 1'b0;
        wait_queue(20);
        repeat (50) @(negedge clk);
        step();
        reset = 1'b0;
        #2;
        check("arst_uart_start", 32'(uart_start), 32'd0);
        check("arst_uart_blank", 32'(uart_blank), 32'd1);
        check("arst_aux_ready", 32'(aux_ready), 32'd0);
        check("arst_uart_data", 32'(uart_data), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        check("arst_seconds", seconds, 32'd0);
        repeat (5) @(negedge clk);
        check("arst_hold_ready", 32'(aux_ready), 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(aux_ready), 32'd1);
        repeat (80) @(negedge clk);
        check("post_rst_blank", 32'(uart_blank), 32'd0);
        check("post_rst_queue", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
